// File: rtl/lc3b_ctrl_pipe_if.sv
// Bus bundle for lc3b_ctrl_pipe: fetch/decode handshake, per-stage stall/flush
// controls, and the per-stage payload and retire outputs.
interface lc3b_ctrl_pipe_if #(
  parameter int CW_WIDTH    = 24,
  parameter int STAGES      = 4,
  parameter int WORD_WIDTH  = 16,
  parameter int COUNT_WIDTH = 32
);
  logic                           in_valid;
  logic                           in_ready;
  logic [CW_WIDTH-1:0]            in_ctrl;
  logic [WORD_WIDTH-1:0]          in_pc;
  logic [WORD_WIDTH-1:0]          in_ir;
  logic [STAGES-1:0]              stall;
  logic [STAGES-1:0]              flush;
  logic [STAGES-1:0]              stage_valid;
  logic [STAGES*CW_WIDTH-1:0]     stage_ctrl;
  logic [STAGES*WORD_WIDTH-1:0]   stage_pc;
  logic [STAGES*WORD_WIDTH-1:0]   stage_ir;
  logic                           retire;
  logic [COUNT_WIDTH-1:0]         retire_count;

  modport master (
    output in_valid, in_ctrl, in_pc, in_ir, stall, flush,
    input  in_ready, stage_valid, stage_ctrl, stage_pc, stage_ir, retire, retire_count
  );

  modport slave (
    input  in_valid, in_ctrl, in_pc, in_ir, stall, flush,
    output in_ready, stage_valid, stage_ctrl, stage_pc, stage_ir, retire, retire_count
  );
endinterface

// File: rtl/lc3b_ctrl_pipe.sv
// Parametrised LC-3b pipeline register: per-stage ctrl/PC/IR/valid with stall,
// bubble insertion, flush, input handshake and a retired-instruction counter.
module lc3b_ctrl_pipe #(
  parameter int CW_WIDTH    = 24,
  parameter int STAGES      = 4,
  parameter int WORD_WIDTH  = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  lc3b_ctrl_pipe_if.slave   bus
);
  logic [STAGES-1:0]                 vld, h, f, ld_v;
  logic [STAGES-1:0][CW_WIDTH-1:0]   ctrl, ld_c;
  logic [STAGES-1:0][WORD_WIDTH-1:0] pc, ir, ld_p, ld_i;
  logic [COUNT_WIDTH-1:0]            cnt;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // A stall or flush in any older stage reaches every younger stage.
    assign h[k] = |bus.stall[STAGES-1:k];
    assign f[k] = |bus.flush[STAGES-1:k];
    if (k == 0) begin : g_head
      assign ld_v[k] = bus.in_valid & bus.in_ready;
      assign ld_c[k] = bus.in_valid ? bus.in_ctrl : '0;
      assign ld_p[k] = bus.in_valid ? bus.in_pc   : '0;
      assign ld_i[k] = bus.in_valid ? bus.in_ir   : '0;
    end else begin : g_body
      // Younger neighbour held while this stage moves on: take a zeroed bubble.
      assign ld_v[k] = vld[k-1] & ~h[k-1];
      assign ld_c[k] = h[k-1] ? '0 : ctrl[k-1];
      assign ld_p[k] = h[k-1] ? '0 : pc[k-1];
      assign ld_i[k] = h[k-1] ? '0 : ir[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= '0;
      ctrl <= '0;
      pc   <= '0;
      ir   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (f[k]) begin
          vld[k]  <= 1'b0;
          ctrl[k] <= '0;
          pc[k]   <= '0;
          ir[k]   <= '0;
        end else if (!h[k]) begin
          vld[k]  <= ld_v[k];
          ctrl[k] <= ld_c[k];
          pc[k]   <= ld_p[k];
          ir[k]   <= ld_i[k];
        end
      end
    end
  end

  assign bus.in_ready = ~h[0] & ~f[0];
  assign bus.retire   = vld[STAGES-1] & ~bus.stall[STAGES-1] & ~bus.flush[STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        cnt <= '0;
    else if (bus.retire) cnt <= cnt + 1'b1;
  end

  assign bus.stage_valid  = vld;
  assign bus.stage_ctrl   = ctrl;
  assign bus.stage_pc     = pc;
  assign bus.stage_ir     = ir;
  assign bus.retire_count = cnt;
endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// Directed + random bench for lc3b_ctrl_pipe against a stage-list reference model.
module tb_lc3b_ctrl_pipe;
  localparam int S  = 4;
  localparam int CW = 24;
  localparam int WW = 16;
  localparam int NW = 4;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [WW-1:0] p;
    logic [WW-1:0] i;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  ent_t m [S];
  logic [NW-1:0] mcount;

  always #5 clk = ~clk;

  lc3b_ctrl_pipe_if #(.CW_WIDTH(CW), .STAGES(S), .WORD_WIDTH(WW), .COUNT_WIDTH(NW)) bus ();

  lc3b_ctrl_pipe #(.CW_WIDTH(CW), .STAGES(S), .WORD_WIDTH(WW), .COUNT_WIDTH(NW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_from(input logic [S-1:0] v, input int k);
    logic r = 1'b0;
    for (int j = k; j < S; j++) r |= v[j];
    return r;
  endfunction

  function automatic logic exp_ready();
    return !any_from(bus.stall, 0) && (bus.flush == '0);
  endfunction

  function automatic logic exp_retire();
    return m[S-1].v && !bus.stall[S-1] && !bus.flush[S-1];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) m[k] = '0;
    mcount = '0;
  endtask

  // Advance the model one edge: each stage is killed, held, bubbled or fed.
  task automatic model_step();
    ent_t nx [S];
    ent_t inc;
    logic rdy = exp_ready();
    inc = '0;
    if (bus.in_valid) inc = '{1'b1, bus.in_ctrl, bus.in_pc, bus.in_ir};
    inc.v = bus.in_valid & rdy;
    if (exp_retire()) mcount = mcount + 1'b1;
    for (int k = 0; k < S; k++) begin
      if (any_from(bus.flush, k))               nx[k] = '0;
      else if (any_from(bus.stall, k))          nx[k] = m[k];
      else if (k > 0 && any_from(bus.stall, k-1)) nx[k] = '0;
      else if (k == 0)                          nx[k] = inc;
      else                                      nx[k] = m[k-1];
    end
    for (int k = 0; k < S; k++) m[k] = nx[k];
  endtask

  task automatic check_state(input string tag);
    logic [S-1:0]    ev = '0;
    logic [S*CW-1:0] ec = '0;
    logic [S*WW-1:0] ep = '0;
    logic [S*WW-1:0] ei = '0;
    for (int k = 0; k < S; k++) begin
      ev[k] = m[k].v;
      ec[k*CW +: CW] = m[k].c;
      ep[k*WW +: WW] = m[k].p;
      ei[k*WW +: WW] = m[k].i;
    end
    chk({tag, ".valid"}, 128'(bus.stage_valid), 128'(ev));
    chk({tag, ".ctrl"},  128'(bus.stage_ctrl),  128'(ec));
    chk({tag, ".pc"},    128'(bus.stage_pc),    128'(ep));
    chk({tag, ".ir"},    128'(bus.stage_ir),    128'(ei));
    chk({tag, ".count"}, 128'(bus.retire_count), 128'(mcount));
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic cycle(input string tag);
    #2;
    chk({tag, ".in_ready"}, 128'(bus.in_ready), 128'(exp_ready()));
    chk({tag, ".retire"},   128'(bus.retire),   128'(exp_retire()));
    @(posedge clk);
    model_step();
    #1;
    check_state(tag);
  endtask

  task automatic drive(input logic v, input logic [S-1:0] st, input logic [S-1:0] fl);
    bus.in_valid = v;
    bus.in_ctrl  = CW'($urandom);
    bus.in_pc    = WW'($urandom);
    bus.in_ir    = WW'($urandom);
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  task automatic fill(input string tag);
    for (int n = 0; n < S; n++) begin
      drive(1'b1, '0, '0);
      cycle(tag);
    end
  endtask

  // Assert reset between edges, check it takes effect at once, release mid-cycle.
  task automatic do_reset(input string tag);
    drive(1'b0, '0, '0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_state(tag);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, '0, '0);
    model_reset();
    #2;
    check_state("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single instruction walks the pipe and retires once.
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 24'h1234AB;
    bus.in_pc    = 16'h3000;
    bus.in_ir    = 16'h1261;
    bus.stall    = '0;
    bus.flush    = '0;
    cycle("t1.e0");
    chk("t1.s0.ctrl", 128'(bus.stage_ctrl[0 +: CW]), 128'(24'h1234AB));
    for (int k = 1; k < S; k++) begin
      drive(1'b0, '0, '0);
      cycle("t1.walk");
      chk("t1.sk.ctrl", 128'(bus.stage_ctrl[k*CW +: CW]), 128'(24'h1234AB));
      chk("t1.sk.pc",   128'(bus.stage_pc[k*WW +: WW]),   128'(16'h3000));
    end
    chk("t1.only_s3", 128'(bus.stage_ctrl[0 +: 3*CW]), 128'(0));
    #2;
    chk("t1.retire", 128'(bus.retire), 128'(1));
    @(negedge clk);
    @(posedge clk);
    model_step();
    #1;
    chk("t1.count", 128'(bus.retire_count), 128'(1));
    check_state("t1.tail");

    // Stall at stage 2 for two cycles, then release.
    fill("t2.fill");
    drive(1'b1, 4'b0100, '0);
    cycle("t2.stall");
    chk("t2.s3_bubble", 128'(bus.stage_valid[3]), 128'(0));
    chk("t2.s3_ctrl",   128'(bus.stage_ctrl[3*CW +: CW]), 128'(0));
    drive(1'b1, 4'b0100, '0);
    cycle("t2.stall2");
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, '0, '0);
      cycle("t2.flow");
    end

    // Flush 2 with stall 3 in the same cycle.
    fill("t3.fill");
    drive(1'b1, 4'b1000, 4'b0100);
    #2;
    chk("t3.ready",  128'(bus.in_ready), 128'(0));
    chk("t3.retire", 128'(bus.retire),   128'(0));
    #1;
    cycle("t3.edge");
    chk("t3.valid", 128'(bus.stage_valid), 128'(4'b1000));

    // Stall and flush both at stage 1: flush wins, stage 2 advances.
    fill("t4.fill");
    drive(1'b1, 4'b0010, 4'b0010);
    cycle("t4.edge");
    chk("t4.valid", 128'(bus.stage_valid), 128'(4'b1000));

    // Counter wraps in NW bits.
    do_reset("t5.reset");
    for (int n = 0; n < 17 + S; n++) begin
      drive(1'b1, '0, '0);
      cycle("t5.stream");
    end
    chk("t5.wrap", 128'(bus.retire_count), 128'(1));

    // Mid-stream reset discards everything; fresh instruction then flows.
    fill("t6.fill");
    do_reset("t6.reset");
    drive(1'b1, '0, '0);
    cycle("t6.inj");
    for (int n = 0; n < S - 1; n++) begin
      drive(1'b0, '0, '0);
      cycle("t6.walk");
    end
    chk("t6.s3", 128'(bus.stage_valid), 128'(4'b1000));

    // Random traffic with sparse stalls and flushes.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0) ? S'($urandom) : '0,
            ($urandom_range(0, 11) == 0) ? S'($urandom) : '0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
